// File: rtl/ascii2hex_pkg.sv
// ascii2hex_pkg: shared definitions for the ASCII-hex stream decoder.
//   - ASCII delimiter constants
//   - decoder state enum
//   - character classification helpers (is_hex_digit, is_delim)
package ascii2hex_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no digits collected yet
    ACCUM = 2'd1,  // collecting hex digits
    SKIP  = 2'd2,  // bad token, discarding up to the next delimiter
    HOLD  = 2'd3   // result pending on the output
  } state_e;

  // 0-9, A-F, a-f
  function automatic logic is_hex_digit(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Token separators: space, CR, LF, comma
  function automatic logic is_delim(input logic [7:0] c);
    return (c == CH_SPACE) || (c == CH_CR) || (c == CH_LF) || (c == CH_COMMA);
  endfunction

endpackage

// File: rtl/ascii2nibble.sv
// ascii2nibble: combinational ASCII hex character to nibble converter.
// Char-level inverse of the nibble-to-ASCII encoder; accepts both cases.
// Ports:
//   ch     in  8  ASCII character
//   nib    out 4  decoded value (0 when ch is not a hex digit)
//   nib_ok out 1  ch is a hex digit
module ascii2nibble
  import ascii2hex_pkg::*;
(
  input  logic [7:0] ch,
  output logic [3:0] nib,
  output logic       nib_ok
);

  always_comb begin
    nib    = 4'h0;
    nib_ok = is_hex_digit(ch);
    if ((ch >= 8'h30) && (ch <= 8'h39)) begin
      nib = 4'(ch - 8'h30);
    end else if ((ch >= 8'h41) && (ch <= 8'h46)) begin
      nib = 4'(ch - 8'h37);  // 'A' (0x41) -> 10
    end else if ((ch >= 8'h61) && (ch <= 8'h66)) begin
      nib = 4'(ch - 8'h57);  // 'a' (0x61) -> 10
    end
  end

endmodule

// File: rtl/ascii2hex_stream.sv
// ascii2hex_stream: streaming ASCII hex text to binary word decoder.
// One character per valid/ready beat; hex digits accumulate MSB-first and
// each delimiter-terminated token yields one result word.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input char handshake
//   in_char  [7:0]        ASCII character
//   out_valid/out_ready   result handshake
//   out_data [W-1:0]      decoded word, right-aligned, zero-extended
//   out_ndigits [CW-1:0]  digits in token (1..DIGITS), 0 on error
//   out_err               token had an invalid char or too many digits
module ascii2hex_stream
  import ascii2hex_pkg::*;
#(
  parameter  int DIGITS = 8,
  localparam int W      = 4 * DIGITS,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_char,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_ndigits,
  output logic          out_err
);

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [CW-1:0] out_ndigits_q, out_ndigits_d;
  logic          out_err_q, out_err_d;

  logic [3:0] nib;
  logic       nib_ok;
  logic       delim;
  logic       fire;

  ascii2nibble u_nib (
    .ch     (in_char),
    .nib    (nib),
    .nib_ok (nib_ok)
  );

  assign delim = is_delim(in_char);

  // Ready depends only on registered state (and reset), never on out_ready,
  // so HOLD always costs at least one stall cycle per token.
  assign in_ready = !rst && (state_q != HOLD);
  assign fire     = in_valid && in_ready;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_ndigits_d = out_ndigits_q;
    out_err_d     = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (fire) begin
          if (nib_ok) begin
            acc_d   = W'(nib);
            cnt_d   = CW'(1);
            state_d = ACCUM;
          end else if (!delim) begin
            state_d = SKIP;
          end
          // leading / repeated delimiters are swallowed silently
        end
      end

      ACCUM: begin
        if (fire) begin
          if (nib_ok) begin
            if (cnt_q < CW'(DIGITS)) begin
              acc_d = (acc_q << 4) | W'(nib);
              cnt_d = cnt_q + CW'(1);
            end else begin
              state_d = SKIP;  // one digit too many
            end
          end else if (delim) begin
            out_valid_d   = 1'b1;
            out_data_d    = acc_q;
            out_ndigits_d = cnt_q;
            out_err_d     = 1'b0;
            state_d       = HOLD;
          end else begin
            state_d = SKIP;
          end
        end
      end

      SKIP: begin
        // Everything up to the delimiter belongs to the same bad token,
        // so exactly one error result is produced for it.
        if (fire && delim) begin
          out_valid_d   = 1'b1;
          out_data_d    = '0;
          out_ndigits_d = '0;
          out_err_d     = 1'b1;
          state_d       = HOLD;
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_ndigits_q <= '0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_ndigits_q <= out_ndigits_d;
      out_err_q     <= out_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ndigits = out_ndigits_q;
  assign out_err     = out_err_q;

endmodule

// File: tb/tb_ascii2hex_stream.sv
// Bench for ascii2hex_stream (DIGITS=8): reset check, hand-written handshake
// sequences, a table of single-token vectors and a randomized character
// stream checked against a token-level reference model.
module tb_ascii2hex_stream;

  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_ndigits;
  logic        out_err;

  ascii2hex_stream #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_char     (in_char),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ndigits (out_ndigits),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  n;
    logic        e;
  } res_t;

  typedef struct {
    string       txt;
    logic [31:0] d;
    logic [3:0]  n;
    logic        e;
  } vec_t;

  res_t res_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   valid_seen = 0;
  int   ready_low  = 0;
  bit   rand_rdy = 0;
  bit   rand_gap = 0;

  // Outputs sampled on the falling edge; inputs change 1 ns after rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid) valid_seen++;
    if (!rst && !in_ready) ready_low++;
    if (!rst && out_valid && out_ready) begin
      res_q.push_back('{d: out_data, n: out_ndigits, e: out_err});
      $display("out: data=%08h ndigits=%0d err=%0b", out_data, out_ndigits, out_err);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    int k;
    if (rand_gap && ($urandom_range(0, 3) == 0)) begin
      in_valid = 1'b0;
      in_char  = 8'h47;  // garbage while not valid must be ignored
      tick();
    end
    in_valid = 1'b1;
    in_char  = c;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      $display("FAIL send_timeout: in_ready got 0 expected 1");
      n_total++;
    end
    tick();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n);
    int k = 0;
    while (res_q.size() < n && k < 3000) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk("result_count", 64'(res_q.size()), 64'(n));
  endtask

  task automatic chk_res(input string name, input logic [31:0] d, input logic [3:0] n, input logic e);
    res_t r;
    if (res_q.size() == 0) begin
      chk({name, "_missing"}, 64'(0), 64'(1));
    end else begin
      r = res_q.pop_front();
      chk(name, {27'd0, r.d, r.n, r.e}, {27'd0, d, n, e});
    end
  endtask

  // Reference model: split on delimiters; each non-empty token gives one
  // result, an error if it holds a non-hex char or more than DIGITS digits.
  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic bit delim_ref(input logic [7:0] c);
    return c == 8'd32 || c == 8'd13 || c == 8'd10 || c == 8'd44;
  endfunction

  task automatic model(input logic [7:0] s[$], output res_t exp[$]);
    int len = 0;
    bit bad = 0;
    longint unsigned v = 0;
    exp = {};
    foreach (s[i]) begin
      if (delim_ref(s[i])) begin
        if (len > 0 || bad) begin
          if (bad || len > DIGITS) exp.push_back('{d: 32'd0, n: 4'd0, e: 1'b1});
          else exp.push_back('{d: 32'(v), n: 4'(len), e: 1'b0});
        end
        len = 0; bad = 0; v = 0;
      end else if (hexval(s[i]) < 0) begin
        bad = 1;
      end else begin
        v = v * 16 + longint'(hexval(s[i]));
        len++;
      end
    end
  endtask

  function automatic logic [7:0] rand_digit();
    logic [7:0] tbl [0:21];
    string h = "0123456789abcdefABCDEF";
    for (int i = 0; i < 22; i++) tbl[i] = h[i];
    return tbl[$urandom_range(0, 21)];
  endfunction

  function automatic logic [7:0] rand_delim();
    logic [7:0] tbl [0:3];
    tbl[0] = 8'h20; tbl[1] = 8'h0D; tbl[2] = 8'h0A; tbl[3] = 8'h2C;
    return tbl[$urandom_range(0, 3)];
  endfunction

  function automatic logic [7:0] rand_bad();
    logic [7:0] tbl [0:5];
    tbl[0] = "G"; tbl[1] = "z"; tbl[2] = "!"; tbl[3] = "."; tbl[4] = "x"; tbl[5] = 8'h09;
    return tbl[$urandom_range(0, 5)];
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [7:0]  stream[$];
    res_t        exp[$];
    int          len;

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_ndigits", 64'(out_ndigits), 64'(0));
    chk("rst_out_err", 64'(out_err), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    tick();
    rst = 1'b0;
    tick();

    // ---------------- "1A2f\n": one-cycle result after the delimiter ----
    out_ready = 1'b1;
    send_str("1A2f\n");
    @(negedge clk);
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_data", 64'(out_data), 64'h1A2F);
    chk("t1_ndigits", 64'(out_ndigits), 64'(4));
    chk("t1_err", 64'(out_err), 64'(0));
    chk("t1_in_ready_hold", 64'(in_ready), 64'(0));
    tick();
    @(negedge clk);
    chk("t1_valid_drop", 64'(out_valid), 64'(0));
    tick();
    res_q = {};

    // ---------------- back-pressure during HOLD ----------------
    out_ready = 1'b0;
    send_str("DEADBEEF ");
    in_valid = 1'b1;
    in_char  = "1";
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(out_valid), 64'(1));
      chk("t2_hold_data", 64'(out_data), 64'hDEADBEEF);
      chk("t2_hold_nd", 64'(out_ndigits), 64'(8));
      chk("t2_hold_ready", 64'(in_ready), 64'(0));
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_ready_still_low", 64'(in_ready), 64'(0));
    tick();
    @(negedge clk);
    chk("t2_valid_drop", 64'(out_valid), 64'(0));
    chk("t2_ready_back", 64'(in_ready), 64'(1));
    tick();  // '1' accepted here
    send_str("\n");
    wait_res(2);
    chk_res("t2_res0", 32'hDEADBEEF, 4'd8, 1'b0);
    chk_res("t2_res1", 32'h1, 4'd1, 1'b0);

    // ---------------- table of single-token vectors ----------------
    vecs.push_back('{txt: "1A2f\n",          d: 32'h00001A2F, n: 4'd4, e: 1'b0});
    vecs.push_back('{txt: "123456789\r",     d: 32'h0,        n: 4'd0, e: 1'b1});
    vecs.push_back('{txt: "5\r",             d: 32'h5,        n: 4'd1, e: 1'b0});
    vecs.push_back('{txt: "12G4,",           d: 32'h0,        n: 4'd0, e: 1'b1});
    vecs.push_back('{txt: "7\n",             d: 32'h7,        n: 4'd1, e: 1'b0});
    vecs.push_back('{txt: "ffffffff,",       d: 32'hFFFFFFFF, n: 4'd8, e: 1'b0});
    vecs.push_back('{txt: "abcDEF01 ",       d: 32'hABCDEF01, n: 4'd8, e: 1'b0});
    vecs.push_back('{txt: "  \r\n0\n",       d: 32'h0,        n: 4'd1, e: 1'b0});
    vecs.push_back('{txt: "z\n",             d: 32'h0,        n: 4'd0, e: 1'b1});
    vecs.push_back('{txt: "G12345678901 ",   d: 32'h0,        n: 4'd0, e: 1'b1});
    vecs.push_back('{txt: "0009\r",          d: 32'h9,        n: 4'd4, e: 1'b0});
    foreach (vecs[i]) begin
      res_q = {};
      send_str(vecs[i].txt);
      wait_res(1);
      chk_res($sformatf("vec%0d", i), vecs[i].d, vecs[i].n, vecs[i].e);
      $display("vec %0d: expected data=%08h ndigits=%0d err=%0b", i, vecs[i].d, vecs[i].n, vecs[i].e);
    end

    // ---------------- delimiters only: nothing produced ----------------
    res_q = {};
    valid_seen = 0;
    ready_low  = 0;
    send_str("\r\n  ,\n");
    repeat (4) tick();
    chk("t5_no_valid", 64'(valid_seen), 64'(0));
    chk("t5_ready_high", 64'(ready_low), 64'(0));

    // ---------------- reset mid-token ----------------
    res_q = {};
    send_str("AB");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_str("C\n");
    wait_res(1);
    chk_res("t6_after_rst", 32'hC, 4'd1, 1'b0);

    // ---------------- reset during HOLD ----------------
    res_q = {};
    out_ready = 1'b0;
    send_str("5\n");
    @(negedge clk);
    chk("t6_hold_valid", 64'(out_valid), 64'(1));
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", 64'(in_ready), 64'(0));
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid_drop", 64'(out_valid), 64'(0));
    repeat (4) tick();
    chk("t6_result_lost", 64'(res_q.size()), 64'(0));

    // ---------------- randomized stream vs reference model ----------------
    res_q  = {};
    stream = {};
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          len = $urandom_range(1, DIGITS);
          for (int k = 0; k < len; k++) stream.push_back(rand_digit());
        end
        3: begin
          len = $urandom_range(DIGITS + 1, DIGITS + 3);
          for (int k = 0; k < len; k++) stream.push_back(rand_digit());
        end
        default: begin
          len = $urandom_range(1, 5);
          for (int k = 0; k < len; k++) begin
            if (k == 2) stream.push_back(rand_bad());
            else stream.push_back(rand_digit());
          end
          if (len < 3) stream.push_back(rand_bad());
        end
      endcase
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) stream.push_back(rand_delim());
    end
    model(stream, exp);
    rand_rdy = 1;
    rand_gap = 1;
    foreach (stream[i]) send_char(stream[i]);
    in_valid = 1'b0;
    rand_gap = 0;
    wait_res(exp.size());
    rand_rdy = 0;
    out_ready = 1'b1;
    foreach (exp[i]) chk_res($sformatf("rand%0d", i), exp[i].d, exp[i].n, exp[i].e);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ascii2hex_stream.md
Name: ascii2hex_stream

Overview:
Streaming decoder that turns ASCII hex text into binary words, the inverse of the team's nibble-to-ASCII encoder. Consumes one ASCII char per valid/ready beat, accumulates hex digits MSB-first, and emits one word per delimiter-terminated token. Sits behind a UART RX or debug console byte stream and feeds a register-write or command path.

Parameters:
DIGITS, 8, max hex digits per token; output word width W = 4*DIGITS (localparam)
CW, $clog2(DIGITS+1), localparam, width of the digit counter and out_ndigits

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
in_valid  in  1  in_char valid
in_ready  out  1  block accepts in_char this cycle
in_char  in  8  ASCII character
out_valid  out  1  token result available
out_ready  in  1  downstream accepts result
out_data  out  W  decoded word, right-aligned, zero-extended
out_ndigits  out  CW  digits in token (1..DIGITS), 0 on error
out_err  out  1  token contained an invalid char or exceeded DIGITS

Behaviour:
- Beat accepted when in_valid && in_ready. in_ready = !rst && (state != HOLD), derived from registered state only, no combinational path from out_ready.
- Char classes:
  - digit: 0x30-0x39 -> 0-9; 0x41-0x46 and 0x61-0x66 -> A-F (case-insensitive).
  - delimiter: 0x20, 0x0D, 0x0A, 0x2C.
  - anything else is invalid.
- States: IDLE (no digits yet), ACCUM (collecting), SKIP (error, discarding to delimiter), HOLD (result pending).
- IDLE:
  - digit -> acc = nibble, cnt = 1, ACCUM.
  - delimiter -> ignored, stay (CRLF, repeated spaces produce no output).
  - invalid -> SKIP.
- ACCUM:
  - digit with cnt < DIGITS -> acc = {acc[W-5:0], nib}, cnt++.
  - digit with cnt == DIGITS -> overflow, SKIP.
  - invalid -> SKIP.
  - delimiter -> load out_data = acc, out_ndigits = cnt, out_err = 0; HOLD.
- SKIP:
  - digits and invalid chars are consumed and discarded.
  - delimiter -> out_data = 0, out_ndigits = 0, out_err = 1; HOLD.
  - Exactly one error result per bad token.
- HOLD:
  - out_valid = 1; out_data, out_ndigits and out_err are stable until out_ready.
  - in_ready = 0.
  - When out_valid && out_ready: out_valid drops next cycle, state IDLE, acc and cnt cleared.
- Latency: out_valid asserts the cycle after the delimiter beat. Max throughput is one char per cycle, plus at least one stall cycle per token.
- Reset values: out_valid 0, out_data 0, out_ndigits 0, out_err 0, state IDLE, acc 0, cnt 0. in_ready is 0 while rst is high.
- Reset mid-token or during HOLD: partial accumulator and pending result are discarded; no output.
- in_char is ignored when in_valid is 0. An in_valid/in_char change while in_ready=0 has no effect.

Decomposition:
- Package ascii2hex_pkg:
  - char constants (CH_SPACE, CH_CR, CH_LF, CH_COMMA);
  - state enum (IDLE, ACCUM, SKIP, HOLD);
  - functions is_hex_digit, is_delim.
- Sub-module ascii2nibble: combinational, 8-bit char in -> 4-bit nibble plus valid flag; the char-level inverse of the existing nibble-to-ASCII encoder.
- Top module holds the FSM, accumulator, counter and output registers.

Test Plan:
1. DIGITS=8, send "1A2f\n", out_ready=1 -> one result: out_data=0x00001A2F, out_ndigits=4, out_err=0, out_valid high 1 cycle starting the cycle after '\n'.
2. Send "DEADBEEF " with out_ready=0 for 5 cycles, in_valid held with next char '1' -> out_data=0xDEADBEEF, out_ndigits=8 held stable, in_ready=0, '1' not consumed until one cycle after out_ready rises.
3. Send "123456789\r" -> single result: out_err=1, out_data=0, out_ndigits=0; then "5\r" -> out_data=0x5, out_ndigits=1, out_err=0.
4. Send "12G4,7\n" -> first result out_err=1, second result out_data=0x7, out_ndigits=1, out_err=0.
5. Send "\r\n  ,\n" -> no out_valid ever asserted; in_ready stays 1.
6. Send "AB", pulse rst 1 cycle, then "C\n" -> only result out_data=0xC, out_ndigits=1. Separately, rst asserted during HOLD -> out_valid=0 the next cycle and the result is lost.
